uart2bram: RTL
==============

UART2BRAM -- requirements
Module: uart2bram

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, BRAM address width.
REQ-002 SHALL have parameter CLK_FREQ, default 125000000, clock frequency in Hz.
REQ-003 SHALL have parameter BAUD, default 115200, UART bit rate.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 20, number of idle bit-times after which a half-assembled word is discarded.
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rx_uart  input  1  asynchronous UART line, 8N1, idle high.
REQ-008 SHALL have port data_bram  output  16  BRAM write data.
REQ-009 SHALL have port addr_bram  output  ADDR_W  BRAM write address.
REQ-010 SHALL have port en_bram  output  1  BRAM enable.
REQ-011 SHALL have port we_bram  output  1  BRAM write enable.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port word_cnt  output  ADDR_W+1  count of words written since reset, saturating at all-ones.

Function
REQ-014 SHALL synchronise rx_uart through 2 flip-flops, reset to 1; all decoding SHALL use the synchronised signal.
REQ-015 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), which is 1085 at the defaults.
REQ-016 SHALL implement the states IDLE, START, DATA and STOP.
REQ-017 SHALL move IDLE->START on a synchronised high-to-low edge.
REQ-018 In START, SHALL resample the line at CLKS_PER_BIT/2 and go to DATA if it is low, else back to IDLE (glitch rejection).
REQ-019 In DATA, SHALL sample 8 bits LSB first, each CLKS_PER_BIT after the previous sample, then go to STOP.
REQ-020 In STOP, SHALL sample once after CLKS_PER_BIT, then return to IDLE.
REQ-021 A high stop bit SHALL accept the byte; a low stop bit SHALL discard the byte and pulse frame_err for 1 cycle.
REQ-022 Word assembly SHALL take the first accepted byte as the low byte and the second as the high byte: data_bram = {byte1, byte0}.
REQ-023 On the accept of byte1, en_bram and we_bram SHALL assert together for exactly 1 cycle, on the cycle after the STOP sample, with data_bram and addr_bram valid in that cycle.
REQ-024 addr_bram SHALL increment by 1 on the cycle after each write and SHALL wrap from 2^ADDR_W-1 to 0.
REQ-025 word_cnt SHALL increment on each write.
REQ-026 A discarded byte (frame error) SHALL NOT change the byte phase.
REQ-027 If the line stays idle for TIMEOUT_BITS*CLKS_PER_BIT cycles while a low byte is held, the low byte SHALL be dropped and the byte phase reset to low, with no write.
REQ-028 A start edge seen in the same cycle that the timeout expires SHALL be processed as a new start, and the timeout SHALL take effect first.
REQ-029 en_bram and we_bram SHALL be 0 in every cycle other than a write cycle.

Reset
REQ-030 While rst=0, SHALL force state IDLE, all counters 0, addr_bram 0, word_cnt 0, data_bram 0, en_bram 0, we_bram 0, frame_err 0, byte phase low, and synchroniser flops 1.
REQ-031 A reset asserted mid-byte or mid-word SHALL discard any partial data, with no write after release.
REQ-032 After release, reception SHALL resume only on the next falling edge.

Structure
REQ-033 SHALL place the state enum and the CLKS_PER_BIT calculation function in a shared package, uart_pkg, which the transmitter also uses.
REQ-034 SHALL split the byte receiver (REQ-014..021) into a sub-module uart_rx_byte with outputs byte_o, byte_valid_o and frame_err_o; word assembly and BRAM addressing SHALL stay in uart2bram.
REQ-035 The RTL SHALL be 120-400 lines in total.

Verification
REQ-036 Send 0x34 then 0x12 at 115200 baud -> exactly one cycle with en_bram=we_bram=1, data_bram=0x1234, addr_bram=0; afterwards addr_bram=1 and word_cnt=1.
REQ-037 Send 0x34, then 0x56 with a low stop bit, then 0x12 -> one frame_err pulse; single write of 0x1234 at addr 0.
REQ-038 Drive a 300-cycle low glitch on rx_uart -> no state leaves IDLE for more than a half bit, no write, no frame_err.
REQ-039 Set ADDR_W=3 and send 9 words 0x0000..0x0008 -> word 8 written at addr 0, and word_cnt=9.
REQ-040 Send 0xAB, idle for 25 bit-times, then send 0xCD and 0xEF -> a single write of 0xEFCD.
REQ-041 Assert rst for 10 cycles during the 4th data bit of the high byte -> no write, addr_bram=0, and the next byte pair is written at addr 0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : receiver state encoding and bit-period helper shared by UART RX/TX
// Revision : 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_byte : 8N1 byte receiver with 2-flop synchroniser and glitch reject
// Revision     : 1.0
// ---------------------------------------------------------------------------
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 125000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned      CPB       = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned      CNT_W     = $clog2(CPB);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  logic             rx_prev_q, rx_prev_d;
  logic             rx_s, fall;
  uart_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q, byte_q;
  logic             valid_q, ferr_q;

  always_comb begin
    sync_d    = {sync_q[0], rx_i};
    rx_prev_d = sync_q[1];
  end

  assign rx_s = sync_q[1];
  assign fall = rx_prev_q & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (fall) state_q <= START;
        end
        START: begin
          // Mid-start resample: a line already back high was only a glitch.
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_s) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: rtl/uart2bram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart2bram : assembles received byte pairs into 16-bit words, writes BRAM
// Revision  : 1.0
// ---------------------------------------------------------------------------
module uart2bram
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned CLK_FREQ     = 125000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_uart,
  output logic [15:0]       data_bram,
  output logic [ADDR_W-1:0] addr_bram,
  output logic              en_bram,
  output logic              we_bram,
  output logic              frame_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned     TO_CYCLES = TIMEOUT_BITS * clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned     TO_W      = $clog2(TO_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

  logic [7:0]        rx_byte;
  logic              rx_valid, rx_ferr, rx_busy;
  logic              phase_q, phase_d;
  logic [7:0]        low_q, low_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              wr;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst),
    .rx_i         (rx_uart),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr),
    .busy_o       (rx_busy)
  );

  assign wr = rx_valid & phase_q;

  always_comb begin
    phase_d = phase_q;
    low_d   = low_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    // Idle timer only runs while a low byte waits and the receiver is quiet,
    // so a start edge in the expiry cycle still sees the phase reset first.
    if (!phase_q || rx_busy) begin
      to_d = '0;
    end else if (to_q == TO_LAST) begin
      to_d    = '0;
      phase_d = 1'b0;
      low_d   = '0;
    end else begin
      to_d = to_q + TO_ONE;
    end
    if (rx_valid) begin
      to_d = '0;
      if (!phase_q) begin
        low_d   = rx_byte;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        addr_d  = addr_q + 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= 1'b0;
      low_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
    end else begin
      phase_q <= phase_d;
      low_q   <= low_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign data_bram = {rx_byte, low_q};
  assign addr_bram = addr_q;
  assign en_bram   = wr;
  assign we_bram   = wr;
  assign frame_err = rx_ferr;
  assign word_cnt  = cnt_q;

endmodule
`default_nettype wire
